dmem_arbiter: RTL and testbench

Sequences all accesses to the data-memory BRAM (1-cycle registered read, full-word write, word index = addr[ADDR_SIZE:2]) and shares it between two requesters: port 0 = core load/store unit, port 1 = DMA/debug loader. Round-robin arbitration, one transaction in flight. Byte-enabled stores are turned into read-modify-write sequences because the memory writes whole words only. Sits between the core/DMA and the memory instance in the top level.

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter_rr_arb2.sv | 33 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, port ids
// and the byte-lane merge used by read-modify-write stores.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RSP_LD,
        ST_WR_FULL,
        ST_RMW_MERGE,
        ST_ERR
    } state_t;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
// Port p occupies bits [32p+31:32p] of addr/wdata and [4p+3:4p] of be.
interface dmem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or core-always-wins when
// FIXED_PRIO is set. The last-grant flop favours the core out of reset.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       update,
    output logic [1:0] grant
);
    logic last_dma;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                if (FIXED_PRIO || last_dma) grant[PORT_CORE] = 1'b1;
                else                        grant[PORT_DMA]  = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                          last_dma <= 1'b1;
        else if (update && grant != 2'b00) last_dma <= grant[PORT_DMA];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory sequencer shared by the core LSU (port 0) and DMA (port 1);
// partial-byte stores become read-modify-write on the word-only BRAM.
//
// state     | meaning
// IDLE      | ready to grant a request
// RD        | memory read issued (load, or first half of an RMW store)
// RSP_LD    | read data returned to the requester
// WR_FULL   | whole-word store (be==0 responds without writing)
// RMW_MERGE | merged word written back
// ERR       | out-of-range address reported
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 7,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus,
    output logic [31:0]          mem_read_addr,
    output logic [31:0]          mem_write_addr,
    output logic [31:0]          mem_write_data,
    output logic                 mem_write_enable,
    input  logic [31:0]          mem_read_data
);
    state_t      state, state_nxt;
    logic        idle;
    logic [1:0]  grant;
    logic        accept;
    logic        gnt_dma;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_in_range;
    logic        lat_we;
    logic        lat_port;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    assign idle = rst && (state == ST_IDLE);

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (idle),
        .update (idle),
        .grant  (grant)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign gnt_dma       = grant[PORT_DMA];
    assign sel_we        = bus.req_we[gnt_dma];
    assign sel_addr      = gnt_dma ? bus.req_addr[63:32]  : bus.req_addr[31:0];
    assign sel_wdata     = gnt_dma ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    assign sel_be        = gnt_dma ? bus.req_be[7:4]      : bus.req_be[3:0];
    assign sel_in_range  = (sel_addr >> (ADDR_SIZE + 1)) == 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we    <= sel_we;
                lat_port  <= gnt_dma;
                lat_addr  <= {sel_addr[31:2], 2'b00};
                lat_wdata <= sel_wdata;
                lat_be    <= sel_be;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!sel_in_range)                           state_nxt = ST_ERR;
                    else if (!sel_we)                            state_nxt = ST_RD;
                    else if (sel_be == 4'hF || sel_be == 4'h0)   state_nxt = ST_WR_FULL;
                    else                                         state_nxt = ST_RD;
                end
            end
            // The arbiter is disabled outside IDLE, so an RMW cannot be split.
            ST_RD:   state_nxt = lat_we ? ST_RMW_MERGE : ST_RSP_LD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.rsp_valid    = 2'b00;
        bus.rsp_rdata    = 32'd0;
        bus.rsp_err      = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = lat_wdata;
        if (rst) begin
            unique case (state)
                ST_RSP_LD: begin
                    bus.rsp_valid[lat_port] = 1'b1;
                    bus.rsp_rdata           = mem_read_data;
                end
                ST_WR_FULL: begin
                    bus.rsp_valid[lat_port] = 1'b1;
                    mem_write_enable        = (lat_be != 4'h0);
                end
                ST_RMW_MERGE: begin
                    bus.rsp_valid[lat_port] = 1'b1;
                    mem_write_enable        = 1'b1;
                    mem_write_data          = merge_bytes(mem_read_data, lat_wdata, lat_be);
                end
                ST_ERR: begin
                    bus.rsp_valid[lat_port] = 1'b1;
                    bus.rsp_err             = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_read_addr  = lat_addr;
    assign mem_write_addr = lat_addr;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a single driver/monitor loop feeds both
// ports from request queues and checks responses and memory writes.
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus_fp();

    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
    logic        mem_write_enable;
    logic [31:0] fp_read_addr, fp_write_addr, fp_write_data;
    logic        fp_write_enable;

    dmem_arbiter #(.ADDR_SIZE(7), .FIXED_PRIO(1'b0)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .mem_read_addr    (mem_read_addr),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    dmem_arbiter #(.ADDR_SIZE(7), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus_fp),
        .mem_read_addr    (fp_read_addr),
        .mem_write_addr   (fp_write_addr),
        .mem_write_data   (fp_write_data),
        .mem_write_enable (fp_write_enable),
        .mem_read_data    (32'h0)
    );

    // BRAM stand-in: registered read, whole-word write, 32 words.
    logic [31:0] tb_mem [32];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= 32'h0;
        end else if (mem_write_enable) begin
            tb_mem[mem_write_addr[6:2]] <= mem_write_data;
        end
        rd_q <= tb_mem[mem_read_addr[6:2]];
    end
    assign mem_read_data = rd_q;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic [31:0] model_mem [32];
    logic [1:0]  drv_valid;
    req_t        q0[$];
    req_t        q1[$];
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          gnt_port[$];
    int          gnt_cyc[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    task automatic apply_drive();
        drv_valid[0] = (q0.size() > 0);
        drv_valid[1] = (q1.size() > 0);
        bus.req_valid = drv_valid;
        if (drv_valid[0]) begin
            bus.req_we[0]        = q0[0].we;
            bus.req_addr[31:0]   = q0[0].addr;
            bus.req_wdata[31:0]  = q0[0].wdata;
            bus.req_be[3:0]      = q0[0].be;
        end
        if (drv_valid[1]) begin
            bus.req_we[1]        = q1[0].we;
            bus.req_addr[63:32]  = q1[0].addr;
            bus.req_wdata[63:32] = q1[0].wdata;
            bus.req_be[7:4]      = q1[0].be;
        end
    endtask

    task automatic accept(input int p, input req_t r);
        int          idx;
        logic [31:0] merged;
        idx = int'(r.addr[6:2]);
        gnt_port.push_back(p);
        gnt_cyc.push_back(cyc);
        if ((r.addr >> 8) != 32'h0) begin
            rsp_q.push_back('{port: p, rdata: 32'h0, err: 1'b1, cyc: cyc + 1});
        end else if (!r.we) begin
            rsp_q.push_back('{port: p, rdata: model_mem[idx], err: 1'b0, cyc: cyc + 2});
        end else if (r.be == 4'hF) begin
            model_mem[idx] = r.wdata;
            rsp_q.push_back('{port: p, rdata: 32'h0, err: 1'b0, cyc: cyc + 1});
            wr_q.push_back('{addr: {r.addr[31:2], 2'b00}, data: r.wdata, cyc: cyc + 1});
        end else if (r.be == 4'h0) begin
            rsp_q.push_back('{port: p, rdata: 32'h0, err: 1'b0, cyc: cyc + 1});
        end else begin
            merged = ref_merge(model_mem[idx], r.wdata, r.be);
            model_mem[idx] = merged;
            rsp_q.push_back('{port: p, rdata: 32'h0, err: 1'b0, cyc: cyc + 2});
            wr_q.push_back('{addr: {r.addr[31:2], 2'b00}, data: merged, cyc: cyc + 2});
        end
    endtask

    // One clock: drive from queues, sample at negedge, return just after posedge.
    task automatic tick();
        rsp_t       e;
        wr_t        w;
        logic [1:0] rdy;
        apply_drive();
        @(negedge clk);
        cyc++;
        if (bus.rsp_valid != 2'b00) begin
            if (rsp_q.size() == 0) begin
                check_val("rsp_unexpected", {62'h0, bus.rsp_valid}, 64'h0);
            end else begin
                e = rsp_q.pop_front();
                check_val("rsp_port",  {62'h0, bus.rsp_valid}, 64'(2'b01 << e.port));
                check_val("rsp_cycle", 64'(cyc), 64'(e.cyc));
                check_val("rsp_rdata", {32'h0, bus.rsp_rdata}, {32'h0, e.rdata});
                check_val("rsp_err",   {63'h0, bus.rsp_err}, {63'h0, e.err});
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
            e = rsp_q.pop_front();
            check_val("rsp_missing", 64'(cyc), 64'(e.cyc + 1000));
        end
        if (mem_write_enable) begin
            if (wr_q.size() == 0) begin
                check_val("wr_unexpected", {63'h0, mem_write_enable}, 64'h0);
            end else begin
                w = wr_q.pop_front();
                check_val("wr_cycle", 64'(cyc), 64'(w.cyc));
                check_val("wr_addr",  {32'h0, mem_write_addr}, {32'h0, w.addr});
                check_val("wr_data",  {32'h0, mem_write_data}, {32'h0, w.data});
            end
        end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
            w = wr_q.pop_front();
            check_val("wr_missing", 64'(cyc), 64'(w.cyc + 1000));
        end
        rdy = bus.req_ready;
        if (rdy != 2'b00) begin
            check_val("ready_legal", {63'h0, ($countones(rdy) > 1) || ((rdy & ~drv_valid) != 2'b00)}, 64'h0);
            if (rdy[0] && drv_valid[0])      accept(0, q0.pop_front());
            else if (rdy[1] && drv_valid[1]) accept(1, q1.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_traffic(input int budget);
        int n = 0;
        while ((q0.size() + q1.size() + rsp_q.size() + wr_q.size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("traffic_drained", 64'(q0.size() + q1.size() + rsp_q.size() + wr_q.size()), 64'h0);
        tick();
        tick();
    endtask

    task automatic push_req(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        req_t r;
        r = '{we: we, addr: addr, wdata: wdata, be: be};
        if (p == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    initial begin
        int          c0;
        int          fp_grants;
        int          fp_writes;
        logic [31:0] saved;

        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = 64'h0;
        bus.req_wdata = 64'h0;
        bus.req_be    = 8'hFF;
        bus_fp.req_valid = 2'b00;
        bus_fp.req_we    = 2'b11;
        bus_fp.req_addr  = 64'h0;
        bus_fp.req_wdata = {32'h0000_BBBB, 32'h0000_AAAA};
        bus_fp.req_be    = 8'hFF;

        // Reset with both ports requesting: nothing may be accepted or driven.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", {62'h0, bus.req_ready}, 64'h0);
        check_val("rst_rsp_valid", {62'h0, bus.rsp_valid}, 64'h0);
        check_val("rst_rsp_rdata", {32'h0, bus.rsp_rdata}, 64'h0);
        check_val("rst_rsp_err",   {63'h0, bus.rsp_err}, 64'h0);
        check_val("rst_mem_we",    {63'h0, mem_write_enable}, 64'h0);
        check_val("rst_mem_raddr", {32'h0, mem_read_addr}, 64'h0);
        check_val("rst_mem_waddr", {32'h0, mem_write_addr}, 64'h0);
        check_val("rst_mem_wdata", {32'h0, mem_write_data}, 64'h0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        mem_clr = 1'b0;

        // Preload through the DMA port with full-word stores.
        push_req(1, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF);
        push_req(1, 1'b1, 32'h04, 32'h11223344, 4'hF);
        push_req(1, 1'b1, 32'h14, 32'h55667788, 4'hF);
        run_traffic(100);

        // Load: ready in the request cycle, data two cycles later.
        gnt_cyc.delete();
        gnt_port.delete();
        c0 = cyc;
        push_req(0, 1'b0, 32'h0C, 32'h0, 4'h0);
        run_traffic(50);
        check_val("ld_ready_same_cycle", 64'(gnt_cyc[0]), 64'(c0 + 1));

        // Partial store becomes RMW; reads back the merged word, low addr bits ignored.
        push_req(1, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101);
        push_req(0, 1'b0, 32'h04, 32'h0, 4'h0);
        push_req(0, 1'b0, 32'h07, 32'h0, 4'h0);
        push_req(1, 1'b1, 32'h0E, 32'h99887766, 4'b1000);
        push_req(1, 1'b0, 32'h0C, 32'h0, 4'h0);
        run_traffic(100);

        // Out-of-range store and load; be==0 store must not touch memory.
        push_req(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF);
        push_req(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        push_req(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0);
        push_req(0, 1'b0, 32'h14, 32'h0, 4'h0);
        run_traffic(100);

        // Contention: both ports keep full stores pending; grants must alternate.
        gnt_cyc.delete();
        gnt_port.delete();
        for (int k = 0; k < 6; k++) begin
            push_req(0, 1'b1, 32'h40 + 32'(4 * k), $urandom, 4'hF);
            push_req(1, 1'b1, 32'h60 + 32'(4 * k), $urandom, 4'hF);
        end
        run_traffic(200);
        check_val("cont_grants", 64'(gnt_port.size()), 64'd12);
        for (int i = 1; i < gnt_port.size(); i++) begin
            check_val("cont_alternate", 64'(gnt_port[i]), 64'(1 - gnt_port[i-1]));
            check_val("cont_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd2);
        end
        for (int k = 0; k < 6; k += 2) begin
            push_req(1, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0);
            push_req(0, 1'b0, 32'h60 + 32'(4 * k), 32'h0, 4'h0);
        end
        run_traffic(200);

        // Reset during the RD cycle of a core RMW store: dropped, and core wins afterwards.
        saved = model_mem[8];
        push_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0011);
        for (int n = 0; n < 10 && q0.size() > 0; n++) tick();
        check_val("rmw_accepted", 64'(q0.size()), 64'h0);
        rst = 1'b0;
        rsp_q.delete();
        wr_q.delete();
        model_mem[8] = saved;
        tick();
        rst = 1'b1;
        tick();
        tick();
        gnt_cyc.delete();
        gnt_port.delete();
        push_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        push_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        run_traffic(50);
        check_val("post_rst_grants", 64'(gnt_port.size()), 64'd2);
        check_val("post_rst_first", 64'(gnt_port[0]), 64'd0);

        // Fixed priority instance: the DMA port never wins while the core keeps asking.
        fp_grants = 0;
        fp_writes = 0;
        bus_fp.req_valid = 2'b11;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check_val("fp_no_dma_grant", {63'h0, bus_fp.req_ready[1]}, 64'h0);
            if (bus_fp.req_ready[0]) fp_grants++;
            if (fp_write_enable) begin
                fp_writes++;
                check_val("fp_wdata", {32'h0, fp_write_data}, 64'h0000_AAAA);
                check_val("fp_waddr", {32'h0, fp_write_addr | fp_read_addr}, 64'h0);
                check_val("fp_rsp",   {61'h0, bus_fp.rsp_valid, bus_fp.rsp_err}, 64'b010);
                check_val("fp_rdata", {32'h0, bus_fp.rsp_rdata}, 64'h0);
            end
            @(posedge clk);
            #1;
        end
        bus_fp.req_valid = 2'b00;
        check_val("fp_core_grants", 64'(fp_grants), 64'd6);
        check_val("fp_core_writes", 64'(fp_writes), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
